mod_updown_counter: RTL and testbench

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

---
 rtl/mod_updown_counter.sv | 100 ++++++++++
 tb/tb_mod_updown_counter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// Up/down counter with runtime limit, wrap or saturate terminal mode,
// synchronous load, terminal-count pulse and a saturating wrap counter.
module mod_updown_counter #(
  parameter int WIDTH = 4,
  parameter int WRAPW = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic [WRAPW-1:0] wrap_count
);

  logic [WIDTH-1:0] count_nx;
  logic             tc_nx;
  logic             wrap_inc;

  logic below;
  logic above;
  logic zero;

  assign below = count < limit;
  assign above = count > limit;
  assign zero  = count == '0;

  logic up_inc, up_wrap, up_sat;
  logic dn_clip, dn_dec, dn_wrap, dn_sat;

  // Mutually exclusive step kinds; zero and above cannot both hold.
  assign up_inc  = up & below;
  assign up_wrap = up & ~below & ~mode;
  assign up_sat  = up & ~below & mode;
  assign dn_clip = ~up & above;
  assign dn_dec  = ~up & ~above & ~zero;
  assign dn_wrap = ~up & zero & ~mode;
  assign dn_sat  = ~up & zero & mode;

  always_comb begin
    count_nx = count;
    tc_nx    = 1'b0;
    wrap_inc = 1'b0;
    if (load) begin
      count_nx = (load_value > limit)
               ? limit : load_value;
    end else if (enable) begin
      unique case (1'b1)
        up_inc: begin
          count_nx = count + 1'b1;
        end
        up_wrap: begin
          count_nx = '0;
          tc_nx    = 1'b1;
          wrap_inc = 1'b1;
        end
        up_sat: begin
          count_nx = limit;
          tc_nx    = 1'b1;
        end
        dn_clip: begin
          count_nx = limit;
        end
        dn_dec: begin
          count_nx = count - 1'b1;
        end
        dn_wrap: begin
          count_nx = limit;
          tc_nx    = 1'b1;
          wrap_inc = 1'b1;
        end
        dn_sat: begin
          count_nx = '0;
          tc_nx    = 1'b1;
        end
        default: begin
          count_nx = count;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count      <= '0;
      tc         <= 1'b0;
      wrap_count <= '0;
    end else begin
      count <= count_nx;
      tc    <= tc_nx;
      if (wrap_inc && (wrap_count != '1))
        wrap_count <= wrap_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: directed scenarios plus random steps
// against an arithmetic model; a WRAPW=2 twin checks wrap saturation.
module tb_mod_updown_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       up = 1'b1;
  logic       mode = 1'b0;
  logic [3:0] limit = 4'd15;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;

  logic [3:0] count, count_s;
  logic       tc, tc_s;
  logic [7:0] wrap_count;
  logic [1:0] wrap_count_s;

  int checks = 0;
  int failures = 0;

  int m_cnt = 0;
  int m_tc = 0;
  int m_wraps = 0;

  mod_updown_counter #(.WIDTH(4), .WRAPW(8)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .up(up), .mode(mode), .limit(limit), .load(load),
    .load_value(load_value), .count(count), .tc(tc),
    .wrap_count(wrap_count)
  );

  mod_updown_counter #(.WIDTH(4), .WRAPW(2)) dut_s (
    .clock(clock), .reset(reset), .enable(enable),
    .up(up), .mode(mode), .limit(limit), .load(load),
    .load_value(load_value), .count(count_s), .tc(tc_s),
    .wrap_count(wrap_count_s)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    int ew, es;
    ew = (m_wraps > 255) ? 255 : m_wraps;
    es = (m_wraps > 3) ? 3 : m_wraps;
    chk({tag, ".count"}, int'(count), m_cnt);
    chk({tag, ".tc"}, int'(tc), m_tc);
    chk({tag, ".wrap"}, int'(wrap_count), ew);
    chk({tag, ".count_s"}, int'(count_s), m_cnt);
    chk({tag, ".tc_s"}, int'(tc_s), m_tc);
    chk({tag, ".wrap_s"}, int'(wrap_count_s), es);
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_tc = 0;
    m_wraps = 0;
  endtask

  // Counts range over 0..lim; wraps are counted unbounded and
  // clamped only when compared.
  task automatic model(input logic en, u, md, ld,
                       input int lim, lv);
    m_tc = 0;
    if (ld) begin
      m_cnt = (lv > lim) ? lim : lv;
    end else if (en) begin
      if (u) begin
        if (m_cnt < lim) m_cnt = m_cnt + 1;
        else begin
          m_tc = 1;
          if (md) m_cnt = lim;
          else begin
            m_cnt = 0;
            m_wraps++;
          end
        end
      end else begin
        if (m_cnt > lim) m_cnt = lim;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
        else begin
          m_tc = 1;
          if (!md) begin
            m_cnt = lim;
            m_wraps++;
          end
        end
      end
    end
  endtask

  task automatic step(input logic en, u, md, ld,
                      input int lim, lv,
                      input string tag);
    enable = en;
    up = u;
    mode = md;
    load = ld;
    limit = 4'(lim);
    load_value = 4'(lv);
    @(posedge clock);
    #1;
    model(en, u, md, ld, lim, lv);
    chk_all(tag);
  endtask

  task automatic idle();
    enable = 1'b0;
    load = 1'b0;
  endtask

  initial begin
    int lim;
    // Reset state
    #1;
    model_reset();
    chk_all("reset");
    @(posedge clock);
    #1;
    chk_all("reset_hold");
    #3 reset = 1'b0;

    // Full-range up count with wrap
    for (int i = 0; i < 17; i++)
      step(1, 1, 0, 0, 15, 0, "up15");
    chk("up15.final", int'(count), 1);
    chk("up15.wraps", int'(wrap_count), 1);

    // Down count, limit 9, from 0
    step(0, 0, 0, 1, 9, 0, "ld0");
    for (int i = 0; i < 11; i++)
      step(1, 0, 0, 0, 9, 0, "dn9");
    chk("dn9.wraps", int'(wrap_count), 3);

    // Saturating up to 5
    step(0, 1, 1, 1, 5, 0, "ld0b");
    for (int i = 0; i < 8; i++)
      step(1, 1, 1, 0, 5, 0, "sat5");
    chk("sat5.count", int'(count), 5);

    // Load clamp, load beats enable, idle hold
    step(0, 1, 0, 1, 7, 12, "ldclamp");
    step(1, 1, 0, 1, 15, 3, "ldwins");
    step(0, 0, 1, 0, 15, 9, "hold");
    step(0, 1, 0, 0, 15, 9, "hold2");

    // Limit lowered below count
    step(0, 1, 0, 1, 15, 10, "ld10");
    step(1, 1, 0, 0, 4, 0, "lower_up");
    step(0, 1, 0, 1, 15, 10, "ld10b");
    step(1, 0, 0, 0, 4, 0, "lower_dn");
    step(1, 0, 1, 0, 4, 0, "after_clip");

    // Limit zero in both modes and directions
    step(1, 1, 0, 0, 0, 0, "lim0_uw");
    step(1, 0, 0, 0, 0, 0, "lim0_dw");
    step(1, 1, 1, 0, 0, 0, "lim0_us");
    step(1, 0, 1, 0, 0, 0, "lim0_ds");

    // Randomized steps
    lim = 15;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0)
        lim = $urandom_range(0, 15);
      step($urandom_range(0, 3) != 0,
           1'($urandom), 1'($urandom_range(0, 3) == 0),
           $urandom_range(0, 9) == 0, lim,
           $urandom_range(0, 15), "rand");
    end

    // Asynchronous reset between edges, count 6 / wraps 3
    idle();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++)
      step(1, 1, 0, 0, 0, 0, "mkwrap");
    step(0, 1, 0, 1, 15, 6, "ld6");
    chk("pre_rst.count", int'(count), 6);
    chk("pre_rst.wrap", int'(wrap_count), 3);
    idle();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk_all("async_rst");

    // Load/enable ignored during reset
    enable = 1'b1;
    load = 1'b1;
    load_value = 4'd5;
    @(posedge clock);
    #1;
    chk_all("rst_ignore");
    idle();
    #2 reset = 1'b0;

    // First enabled edge after release
    step(1, 1, 0, 0, 9, 0, "first_up");
    idle();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    step(1, 0, 0, 0, 9, 0, "first_dn");

    // Wrap counter saturation on the narrow twin
    idle();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++)
      step(1, 1, 0, 0, 0, 0, "wrapsat");
    chk("wrapsat.narrow", int'(wrap_count_s), 3);
    chk("wrapsat.wide", int'(wrap_count), 5);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
